fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the 26-bit jump-target register and the IF/ID register.
- Holds the PC and issues one instruction-memory request at a time. Presents the fetched instruction, PC+4, the 26-bit jump field and the assembled jump address to the next stage through a valid/ready handshake.
- Supports back-pressure and a single-cycle redirect (branch/jump) that kills any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  instruction memory request; held high until imem_ack
- imem_addr  output  32  word address of the outstanding request
- imem_ack  input  1  memory returns imem_rdata this cycle (same-cycle ack allowed)
- imem_rdata  input  32  instruction word, valid when imem_ack
- redirect  input  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address, word aligned
- out_valid  output  1  output register holds a valid instruction
- out_ready  input  1  consumer accepts output this cycle
- out_instr  output  32  fetched instruction
- out_pc4  output  32  fetch address + 4
- out_jtarget  output  26  out_instr[25:0]; feeds the 26-bit jump-target register
- out_jaddr  output  32  {out_pc4[31:28], out_instr[25:0], 2'b00}

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pc=RESET_PC, imem_req=0, out_valid=0.
  - out_instr/out_pc4 = 0, so out_jtarget = 0 and out_jaddr = 0.
- States: IDLE, FETCH, FULL, DRAIN.
- IDLE: imem_req=0.
  - Next edge after reset release → FETCH.
  - A redirect seen in IDLE loads pc.
- FETCH: imem_req=1, imem_addr=pc.
  - Ack → capture rdata into out_instr, out_pc4=pc+4, pc<=pc+4, out_valid<=1, → FULL.
  - No ack → stay.
- FULL: out_valid=1. imem_req = out_ready (combinational); imem_addr=pc.
  - !out_ready → hold all outputs, stay.
  - out_ready & ack → load next instruction, pc<=pc+4, stay FULL (1 instr/cycle with zero-wait memory).
  - out_ready & !ack → out_valid<=0, → FETCH. imem_req stays high at the same address.
- DRAIN: imem_req=1, imem_addr=drain_addr (saved address of the killed request).
  - Ack → data discarded, → FETCH.
- Rule: imem_req never falls and imem_addr never changes while a request is unacknowledged.
- Redirect has priority over ack and out_ready in the same cycle:
  - pc<=redirect_pc, out_valid<=0.
  - Any ack that cycle is discarded; pc is not incremented.
  - If imem_req was high and imem_ack low: save drain_addr, → DRAIN.
  - Otherwise → FETCH.
  - Redirect while in DRAIN: pc updated, stay DRAIN.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. Low two PC bits are always 0; redirect_pc[1:0] is ignored (forced 0).
- Reset mid-operation: immediate return to reset values. No memory response is honoured until after the next FETCH entry.

Test Plan:
- Reset then zero-wait memory (imem_ack=1 always, out_ready=1), RESET_PC=0 → imem_addr 0,4,8,… on consecutive cycles; out_pc4 = 4,8,12,…; out_valid high from cycle 2 onward.
- Memory with 2 wait states, out_ready=1 → imem_req held 3 cycles with a constant imem_addr. One instruction per 3 cycles. out_instr=32'h0800_0123 → out_jtarget=26'h000_0123, out_jaddr=32'h0000_048C (pc4 upper nibble 0).
- out_ready low for 5 cycles while FULL → out_* stable, imem_req=0 throughout. After out_ready rises, the next fetch is at the held pc.
- Redirect to 32'h0000_0100 while a request to 32'h0000_0010 waits → DRAIN with imem_addr=0x10 until ack (data not presented). Then FETCH at 0x100; first out_pc4=0x104.
- Redirect coincident with ack, and redirect_pc=32'hFFFF_FFFC → ack data dropped, next fetch at 0xFFFF_FFFC, then at 0x0000_0000. out_pc4=0 for the first instruction.
- rst_n pulsed low mid-FULL with out_ready=0 → out_valid and imem_req drop immediately. After release, the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: holds the PC, keeps one imem request in flight,
// and presents instr / pc+4 / jump fields through a valid/ready output register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc4,
   output logic [25:0] out_jtarget,
   output logic [31:0] out_jaddr
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned JW   = 26;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_DRAIN} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_drain_addr;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc4;
   logic            r_valid;

   logic            w_req;
   logic            w_load;
   logic            w_clr_valid;
   logic            w_save_drain;
   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_redirect_pc;

   assign w_pc4         = r_pc + XLEN'(4);
   assign w_redirect_pc = redirect_pc & ALIGN_MASK;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state: redirect outranks ack/ready; a still-pending request must drain
   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE) begin
         w_next = S_FETCH;
      end else if (redirect) begin
         w_next = (w_req && !imem_ack) ? S_DRAIN : S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: if (imem_ack) w_next = S_FULL;
            S_FULL:  if (out_ready) w_next = imem_ack ? S_FULL : S_FETCH;
            S_DRAIN: if (imem_ack) w_next = S_FETCH;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Memory request and datapath controls
   always_comb begin
      w_req        = 1'b0;
      imem_addr    = r_pc;
      w_load       = 1'b0;
      w_clr_valid  = redirect;
      w_save_drain = 1'b0;
      case (r_state)
         S_IDLE: w_req = 1'b0;
         S_FETCH: begin
            w_req  = 1'b1;
            w_load = imem_ack && !redirect;
         end
         S_FULL: begin
            w_req  = out_ready;
            w_load = out_ready && imem_ack && !redirect;
            if (out_ready && !imem_ack) w_clr_valid = 1'b1;
         end
         S_DRAIN: begin
            w_req     = 1'b1;
            imem_addr = r_drain_addr;
         end
         default: w_req = 1'b0;
      endcase
      w_save_drain = redirect && w_req && !imem_ack;
   end

   // PC, drain address and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC & ALIGN_MASK;
         r_drain_addr <= '0;
         r_instr      <= '0;
         r_pc4        <= '0;
         r_valid      <= 1'b0;
      end else begin
         if (redirect)    r_pc <= w_redirect_pc;
         else if (w_load) r_pc <= w_pc4;
         if (w_save_drain) r_drain_addr <= imem_addr;
         if (w_load) begin
            r_instr <= imem_rdata;
            r_pc4   <= w_pc4;
         end
         if (w_load)           r_valid <= 1'b1;
         else if (w_clr_valid) r_valid <= 1'b0;
      end
   end

   assign imem_req    = w_req;
   assign out_valid   = r_valid;
   assign out_instr   = r_instr;
   assign out_pc4     = r_pc4;
   assign out_jtarget = r_instr[JW-1:0];
   assign out_jaddr   = {r_pc4[XLEN-1:XLEN-4], r_instr[JW-1:0], 2'b00};

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model of PC / output word / killed
// request, a wait-state memory, directed scenarios and a randomized run.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc4;
   logic [25:0] out_jtarget;
   logic [31:0] out_jaddr;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc4(out_pc4),
      .out_jtarget(out_jtarget), .out_jaddr(out_jaddr)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Model: next fetch address, presented word, and a killed request still owed by memory
   logic        m_started, m_valid, m_drain;
   logic [31:0] m_pc, m_instr, m_pc4, m_drain_addr;
   logic        e_req;
   logic [31:0] e_addr;
   int          mem_left, wait_mode;
   logic        hold_prev;
   logic [31:0] prev_addr;
   logic        s_redir, s_ack, s_req, s_dut_req;
   logic [31:0] s_rpc, s_rdata, s_addr, s_dut_addr;

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return 32'h0800_0123 ^ (a << 4);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_started = 1'b0; m_valid = 1'b0; m_drain = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_drain_addr = 32'h0;
      mem_left = -1; hold_prev = 1'b0; prev_addr = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
      model_reset();
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_out_pc4", out_pc4, 32'h0);
      chk("rst_out_jtarget", 32'(out_jtarget), 32'h0);
      chk("rst_out_jaddr", out_jaddr, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Apply one cycle of inputs, play memory, compare everything against the model
   task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
      out_ready = rdy; redirect = redir; redirect_pc = rpc;
      if (!m_started)   begin e_req = 1'b0; e_addr = m_pc;         end
      else if (m_drain) begin e_req = 1'b1; e_addr = m_drain_addr; end
      else if (m_valid) begin e_req = rdy;  e_addr = m_pc;         end
      else              begin e_req = 1'b1; e_addr = m_pc;         end
      #1;
      if (imem_req && mem_left < 0)
         mem_left = (wait_mode < 0) ? int'($urandom_range(2, 0)) : wait_mode;
      imem_ack   = imem_req && (mem_left == 0);
      imem_rdata = imem_ack ? rdata_of(imem_addr) : $urandom;
      #1;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", imem_addr, e_addr);
      if (hold_prev) begin
         chk("req_held", 32'(imem_req), 32'h1);
         chk("addr_held", imem_addr, prev_addr);
      end
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk("out_instr", out_instr, m_instr);
         chk("out_pc4", out_pc4, m_pc4);
         chk("out_jtarget", 32'(out_jtarget), 32'(m_instr % (1 << 26)));
         chk("out_jaddr", out_jaddr, (m_pc4 & 32'hF000_0000) + ((m_instr % (1 << 26)) * 4));
      end
      s_redir = redir; s_rpc = rpc; s_ack = imem_ack; s_rdata = imem_rdata;
      s_req = e_req; s_addr = e_addr; s_dut_req = imem_req; s_dut_addr = imem_addr;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!m_started) begin
         m_started = 1'b1;
         if (s_redir) m_pc = s_rpc & ~32'd3;
      end else if (s_redir) begin
         if (s_req && !s_ack) begin m_drain = 1'b1; m_drain_addr = s_addr; end
         else m_drain = 1'b0;
         m_pc = s_rpc & ~32'd3;
         m_valid = 1'b0;
      end else if (m_drain) begin
         if (s_ack) m_drain = 1'b0;
      end else if (s_req && s_ack) begin
         m_instr = s_rdata; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
      end else if (s_req) begin
         m_valid = 1'b0;
      end
      if (s_dut_req) mem_left = s_ack ? -1 : mem_left - 1;
      hold_prev = s_dut_req && !s_ack;
      prev_addr = s_dut_addr;
      #1;
   endtask

   initial begin
      #1;
      // Zero-wait memory, consumer always ready
      wait_mode = 0;
      do_reset();
      drive(1'b1, 1'b0, 32'h0); chk("zw_idle_req", 32'(imem_req), 32'h0); tick();
      drive(1'b1, 1'b0, 32'h0); chk("zw_addr0", imem_addr, 32'h0); tick();
      drive(1'b1, 1'b0, 32'h0); chk("zw_addr4", imem_addr, 32'h4);
      chk("zw_pc4_4", out_pc4, 32'h4); chk("zw_valid", 32'(out_valid), 32'h1); tick();
      drive(1'b1, 1'b0, 32'h0); chk("zw_addr8", imem_addr, 32'h8);
      chk("zw_pc4_8", out_pc4, 32'h8); tick();
      repeat (4) begin drive(1'b1, 1'b0, 32'h0); tick(); end

      // Two wait states
      wait_mode = 2;
      do_reset();
      drive(1'b1, 1'b0, 32'h0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h0);
         chk("ws_req", 32'(imem_req), 32'h1); chk("ws_addr", imem_addr, 32'h0);
         tick();
      end
      drive(1'b1, 1'b0, 32'h0);
      chk("ws_valid", 32'(out_valid), 32'h1);
      chk("ws_instr", out_instr, 32'h0800_0123);
      chk("ws_jtarget", 32'(out_jtarget), 32'h0000_0123);
      chk("ws_jaddr", out_jaddr, 32'h0000_048C);
      tick();
      repeat (6) begin drive(1'b1, 1'b0, 32'h0); tick(); end

      // Back-pressure while FULL
      wait_mode = 0;
      do_reset();
      repeat (3) begin drive(1'b1, 1'b0, 32'h0); tick(); end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         chk("bp_req", 32'(imem_req), 32'h0);
         chk("bp_pc4", out_pc4, 32'h8);
         chk("bp_valid", 32'(out_valid), 32'h1);
         tick();
      end
      drive(1'b1, 1'b0, 32'h0);
      chk("bp_resume_req", 32'(imem_req), 32'h1);
      chk("bp_resume_addr", imem_addr, 32'h8);
      tick();

      // Redirect while a request is waiting: drain the killed fetch first
      wait_mode = 3;
      do_reset();
      drive(1'b1, 1'b1, 32'h0000_0010); tick();
      drive(1'b1, 1'b1, 32'h0000_0100); chk("rd_wait_addr", imem_addr, 32'h10); tick();
      wait_mode = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h0);
         chk("rd_drain_addr", imem_addr, 32'h10);
         chk("rd_drain_valid", 32'(out_valid), 32'h0);
         tick();
      end
      drive(1'b1, 1'b0, 32'h0); chk("rd_new_addr", imem_addr, 32'h100); tick();
      drive(1'b1, 1'b0, 32'h0); chk("rd_new_pc4", out_pc4, 32'h104);
      chk("rd_new_valid", 32'(out_valid), 32'h1); tick();

      // Redirect coincident with ack, wrap-around PC
      drive(1'b1, 1'b1, 32'hFFFF_FFFC); chk("wr_ack_seen", 32'(imem_ack), 32'h1); tick();
      drive(1'b1, 1'b0, 32'h0); chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
      chk("wr_dropped", 32'(out_valid), 32'h0); tick();
      drive(1'b1, 1'b0, 32'h0); chk("wr_addr_zero", imem_addr, 32'h0);
      chk("wr_pc4_zero", out_pc4, 32'h0); chk("wr_valid", 32'(out_valid), 32'h1); tick();

      // Reset mid-FULL with consumer stalled
      repeat (2) begin drive(1'b0, 1'b0, 32'h0); tick(); end
      drive(1'b0, 1'b0, 32'h0);
      do_reset();
      drive(1'b1, 1'b0, 32'h0); tick();
      drive(1'b1, 1'b0, 32'h0);
      chk("rr_req", 32'(imem_req), 32'h1); chk("rr_addr", imem_addr, 32'h0);
      tick();

      // Randomized traffic with unaligned redirect targets
      wait_mode = -1;
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 10) < 7, ($urandom % 12) == 0, $urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
